// File: rtl/load_store_unit.sv
// Load/store unit: forms the effective address, rejects illegal or misaligned
// accesses, issues a single lane-positioned memory request with a timeout, and
// returns a sign- or zero-extended load result through a one-cycle strobe.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic                  op_load,
  input  logic                  op_store,
  input  logic [1:0]            op_size,
  input  logic                  op_unsigned,
  input  logic [XLEN-1:0]       base,
  input  logic [XLEN-1:0]       offset,
  input  logic [XLEN-1:0]       store_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [XLEN-1:0]       mem_req_wdata,
  output logic [XLEN/8-1:0]     mem_req_be,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_rdata,
  output logic                  res_valid,
  output logic [XLEN-1:0]       res_data,
  output logic [1:0]            res_error
);

  localparam int BEW = XLEN / 8;
  localparam int LW  = $clog2(BEW);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [16:0]           cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic                  load_q, load_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0]       req_wdata_q, req_wdata_d;
  logic [BEW-1:0]        req_be_q, req_be_d;
  logic                  res_valid_q, res_valid_d;
  logic [XLEN-1:0]       res_data_q, res_data_d;
  logic [1:0]            res_error_q, res_error_d;

  logic [XLEN-1:0]       eff_addr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [LW-1:0]         acc_lane;
  logic                  misaligned;
  logic [BEW-1:0]        acc_be;
  logic [XLEN-1:0]       acc_wdata;
  logic [XLEN-1:0]       rsp_shifted;
  logic [XLEN-1:0]       size_mask;
  logic                  sign_bit;
  logic [XLEN-1:0]       load_result;
  logic [16:0]           cnt_inc;
  logic                  timeout;

  // Decode the offered operation: address, lane, alignment and lane placement.
  always_comb begin
    eff_addr  = base + offset;
    acc_addr  = ADDR_WIDTH'(eff_addr);
    acc_lane  = acc_addr[LW-1:0];
    acc_wdata = store_data << {acc_lane, 3'b000};
    case (op_size)
      2'd0: begin
        misaligned = 1'b0;
        acc_be     = BEW'(1) << acc_lane;
      end
      2'd1: begin
        misaligned = acc_addr[0];
        acc_be     = BEW'(3) << acc_lane;
      end
      2'd2: begin
        misaligned = (acc_addr[1:0] != 2'b00);
        acc_be     = BEW'(15) << acc_lane;
      end
      default: begin
        misaligned = (XLEN == 32) || (acc_addr[2:0] != 3'b000);
        acc_be     = {BEW{1'b1}};
      end
    endcase
  end

  // Pull the addressed bytes down to bit 0 and extend them to full width.
  always_comb begin
    rsp_shifted = mem_rsp_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0: begin
        size_mask = XLEN'(64'hFF);
        sign_bit  = rsp_shifted[7];
      end
      2'd1: begin
        size_mask = XLEN'(64'hFFFF);
        sign_bit  = rsp_shifted[15];
      end
      2'd2: begin
        size_mask = XLEN'(64'hFFFF_FFFF);
        sign_bit  = rsp_shifted[31];
      end
      default: begin
        size_mask = {XLEN{1'b1}};
        sign_bit  = rsp_shifted[XLEN-1];
      end
    endcase
    load_result = rsp_shifted & size_mask;
    if (!unsigned_q && sign_bit) begin
      load_result = load_result | ~size_mask;
    end
  end

  // Next-state and next-output computation for the request/response sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    load_d      = load_q;
    lane_d      = lane_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    cnt_inc     = cnt_q + 17'd1;
    timeout     = (cnt_inc >= 17'(TIMEOUT_CYCLES));
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          size_d     = op_size;
          unsigned_d = op_unsigned;
          load_d     = op_load;
          lane_d     = acc_lane;
          cnt_d      = '0;
          if (op_load == op_store) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_error_d = 2'd3;
          end else if (misaligned) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_error_d = 2'd1;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_write_d = op_store;
            req_addr_d  = {acc_addr[ADDR_WIDTH-1:LW], LW'(0)};
            req_wdata_d = acc_wdata;
            req_be_d    = acc_be;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (mem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end else if (timeout) begin
          state_d     = RESP;
          req_valid_d = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_error_d = 2'd2;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rsp_valid) begin
          state_d     = RESP;
          res_valid_d = 1'b1;
          res_data_d  = load_q ? load_result : '0;
          res_error_d = 2'd0;
        end else if (timeout) begin
          state_d     = RESP;
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_error_d = 2'd2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register state and every output; reset clears everything visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      load_q      <= 1'b0;
      lane_q      <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      load_q      <= load_d;
      lane_q      <= lane_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
    end
  end

  assign op_ready      = (state_q == IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_write = req_write_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_be    = req_be_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_error     = res_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32): one default instance for the
// normal, stall, error and reset cases, one with TIMEOUT_CYCLES=4 for aborts.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_valid_t;
  logic        op_load, op_store, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] base, offset, store_data;
  logic        mem_req_ready, mem_req_ready_t;
  logic        mem_rsp_valid, mem_rsp_valid_t;
  logic [31:0] mem_rsp_rdata;

  logic        op_ready, mem_req_valid, mem_req_write, res_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, res_data;
  logic [3:0]  mem_req_be;
  logic [1:0]  res_error;

  logic        op_ready_t, mem_req_valid_t, mem_req_write_t, res_valid_t;
  logic [31:0] mem_req_addr_t, mem_req_wdata_t, res_data_t;
  logic [3:0]  mem_req_be_t;
  logic [1:0]  res_error_t;

  int total = 0;
  int bad   = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_load(op_load), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .base(base), .offset(offset),
    .store_data(store_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_be(mem_req_be), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .res_valid(res_valid),
    .res_data(res_data), .res_error(res_error)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .op_valid(op_valid_t), .op_ready(op_ready_t),
    .op_load(op_load), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .base(base), .offset(offset),
    .store_data(store_data), .mem_req_valid(mem_req_valid_t),
    .mem_req_ready(mem_req_ready_t), .mem_req_write(mem_req_write_t),
    .mem_req_addr(mem_req_addr_t), .mem_req_wdata(mem_req_wdata_t),
    .mem_req_be(mem_req_be_t), .mem_rsp_valid(mem_rsp_valid_t),
    .mem_rsp_rdata(mem_rsp_rdata), .res_valid(res_valid_t),
    .res_data(res_data_t), .res_error(res_error_t)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation to the chosen instance for exactly one accepting edge.
  task automatic applyStimulus(input bit sel, input logic ld, input logic st,
                               input logic [1:0] sz, input logic uns,
                               input logic [31:0] b, input logic [31:0] o,
                               input logic [31:0] sd);
    op_load     = ld;
    op_store    = st;
    op_size     = sz;
    op_unsigned = uns;
    base        = b;
    offset      = o;
    store_data  = sd;
    if (sel) op_valid_t = 1'b1;
    else     op_valid   = 1'b1;
    tick();
    op_valid   = 1'b0;
    op_valid_t = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Complete an outstanding request: handshake edge, then one response cycle.
  task automatic respond(input logic [31:0] rdata);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  // Directed sequence of scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    op_valid = 1'b0; op_valid_t = 1'b0;
    op_load = 1'b0; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    base = '0; offset = '0; store_data = '0;
    mem_req_ready = 1'b0; mem_req_ready_t = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_valid_t = 1'b0; mem_rsp_rdata = '0;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_op_ready", op_ready, 1);
    checkOutput("rst_req_valid", mem_req_valid, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_error", res_error, 0);
    checkOutput("rst_be", mem_req_be, 0);
    rst = 1'b0;
    tick();

    $display("[TB] lb signed byte in lane 3");
    mem_req_ready = 1'b1;
    applyStimulus(0, 1, 0, 2'd0, 0, 32'h100, 32'd3, 32'h0);
    checkOutput("lb_req_valid", mem_req_valid, 1);
    checkOutput("lb_op_ready", op_ready, 0);
    checkOutput("lb_addr", mem_req_addr, 32'h100);
    checkOutput("lb_be", mem_req_be, 4'h8);
    checkOutput("lb_write", mem_req_write, 0);
    respond(32'h80FF_FFFF);
    checkOutput("lb_res_valid", res_valid, 1);
    checkOutput("lb_res_data", res_data, 32'hFFFF_FF80);
    checkOutput("lb_res_error", res_error, 0);
    tick();
    checkOutput("lb_res_valid_drop", res_valid, 0);
    checkOutput("lb_res_data_hold", res_data, 32'hFFFF_FF80);
    checkOutput("lb_op_ready_back", op_ready, 1);

    $display("[TB] lhu with negative offset");
    applyStimulus(0, 1, 0, 2'd1, 1, 32'h200, 32'hFFFF_FFFE, 32'h0);
    checkOutput("lhu_addr", mem_req_addr, 32'h1FC);
    checkOutput("lhu_be", mem_req_be, 4'hC);
    respond(32'hBEEF_1234);
    checkOutput("lhu_res_valid", res_valid, 1);
    checkOutput("lhu_res_data", res_data, 32'h0000_BEEF);
    tick();

    $display("[TB] sh with ready stalled three cycles");
    mem_req_ready = 1'b0;
    applyStimulus(0, 0, 1, 2'd1, 0, 32'h100, 32'd2, 32'h0000_ABCD);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sh_req_valid", mem_req_valid, 1);
      checkOutput("sh_addr", mem_req_addr, 32'h100);
      checkOutput("sh_wdata", mem_req_wdata, 32'hABCD_0000);
      checkOutput("sh_be", mem_req_be, 4'hC);
      checkOutput("sh_write", mem_req_write, 1);
      if (i == 3) mem_req_ready = 1'b1;
      tick();
    end
    checkOutput("sh_req_dropped", mem_req_valid, 0);
    checkOutput("sh_no_early_res", res_valid, 0);
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    checkOutput("sh_res_valid", res_valid, 1);
    checkOutput("sh_res_data", res_data, 0);
    checkOutput("sh_res_error", res_error, 0);
    tick();

    $display("[TB] error paths");
    applyStimulus(0, 1, 0, 2'd2, 0, 32'h100, 32'd1, 32'h0);
    checkOutput("lw_mis_res_valid", res_valid, 1);
    checkOutput("lw_mis_error", res_error, 1);
    checkOutput("lw_mis_data", res_data, 0);
    checkOutput("lw_mis_no_req", mem_req_valid, 0);
    tick();
    checkOutput("lw_mis_res_drop", res_valid, 0);
    checkOutput("lw_mis_no_req2", mem_req_valid, 0);
    checkOutput("lw_mis_op_ready", op_ready, 1);
    applyStimulus(0, 1, 0, 2'd3, 0, 32'h100, 32'd0, 32'h0);
    checkOutput("ld32_res_valid", res_valid, 1);
    checkOutput("ld32_error", res_error, 1);
    checkOutput("ld32_no_req", mem_req_valid, 0);
    tick();
    applyStimulus(0, 1, 1, 2'd2, 0, 32'h100, 32'd0, 32'h0);
    checkOutput("illop_res_valid", res_valid, 1);
    checkOutput("illop_error", res_error, 3);
    checkOutput("illop_no_req", mem_req_valid, 0);
    tick();
    applyStimulus(0, 0, 0, 2'd2, 0, 32'h100, 32'd0, 32'h0);
    checkOutput("noop_error", res_error, 3);
    tick();

    $display("[TB] timeout with ready never asserted");
    mem_req_ready_t = 1'b0;
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h100, 32'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_req_valid", mem_req_valid_t, 1);
      checkOutput("to_no_res", res_valid_t, 0);
      tick();
    end
    checkOutput("to_res_valid", res_valid_t, 1);
    checkOutput("to_error", res_error_t, 2);
    checkOutput("to_req_dropped", mem_req_valid_t, 0);
    checkOutput("to_data", res_data_t, 0);
    mem_rsp_valid_t = 1'b1;
    mem_rsp_rdata   = 32'h1111_2222;
    tick();
    checkOutput("to_late_rsp_ignored", res_valid_t, 0);
    checkOutput("to_op_ready", op_ready_t, 1);
    checkOutput("to_error_hold", res_error_t, 2);
    tick();
    mem_rsp_valid_t = 1'b0;
    checkOutput("to_late_rsp_ignored2", res_valid_t, 0);

    $display("[TB] response on the timeout cycle wins");
    mem_req_ready_t = 1'b1;
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h100, 32'd8, 32'h0);
    checkOutput("win_addr", mem_req_addr_t, 32'h108);
    tick();
    tick();
    tick();
    checkOutput("win_no_res_yet", res_valid_t, 0);
    mem_rsp_valid_t = 1'b1;
    mem_rsp_rdata   = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid_t = 1'b0;
    checkOutput("win_res_valid", res_valid_t, 1);
    checkOutput("win_error", res_error_t, 0);
    checkOutput("win_data", res_data_t, 32'hCAFE_F00D);
    tick();

    $display("[TB] reset while waiting for a response");
    mem_req_ready = 1'b1;
    applyStimulus(0, 1, 0, 2'd2, 0, 32'h100, 32'd4, 32'h5555_AAAA);
    tick();
    checkOutput("rw_in_wait", mem_req_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rw_req_valid", mem_req_valid, 0);
    checkOutput("rw_write", mem_req_write, 0);
    checkOutput("rw_addr", mem_req_addr, 0);
    checkOutput("rw_wdata", mem_req_wdata, 0);
    checkOutput("rw_be", mem_req_be, 0);
    checkOutput("rw_res_valid", res_valid, 0);
    checkOutput("rw_res_data", res_data, 0);
    checkOutput("rw_res_error", res_error, 0);
    checkOutput("rw_op_ready", op_ready, 1);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    checkOutput("rw_late_rsp_ignored", res_valid, 0);
    tick();
    checkOutput("rw_late_rsp_ignored2", res_valid, 0);
    applyStimulus(0, 1, 0, 2'd2, 0, 32'h100, 32'd4, 32'h0);
    checkOutput("post_addr", mem_req_addr, 32'h104);
    checkOutput("post_be", mem_req_be, 4'hF);
    respond(32'h1234_5678);
    checkOutput("post_res_valid", res_valid, 1);
    checkOutput("post_res_data", res_data, 32'h1234_5678);
    checkOutput("post_res_error", res_error, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
